// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one 8085 ALU opcode at a time, staging the second operand from regfile or memory
module alu_op_sequencer #(
    parameter int         MEM_TIMEOUT = 16,
    parameter logic [7:0] APPROX_OPC  = 8'h08,
    parameter logic [6:0] ACC_RESET   = 7'd64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    input  logic [7:0] instr,
    output logic       instr_ready,
    output logic       reg_oe,
    output logic [2:0] reg_sel,
    output logic       mem_rd,
    output logic       mem_imm,
    input  logic       mem_rdy,
    output logic       tmp_we,
    output logic       cs,
    output logic [4:0] op,
    input  logic       cfg_we,
    input  logic [6:0] cfg_data,
    output logic [6:0] accuracy,
    output logic       busy,
    output logic       done,
    output logic       err
);
    typedef enum logic [2:0] {IDLE, LDREG, FETCH, EXEC, FIN} state_t;
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    state_t        state, dec_state;
    logic [CW-1:0] cnt;
    logic [4:0]    alu_op, dec_op;
    logic [2:0]    dec_sel;
    logic          tmp_q;
    assign instr_ready = state == IDLE;
    assign busy        = state != IDLE;
    // memory write into tmp must coincide with the byte actually being on the bus
    assign tmp_we      = tmp_q | (mem_rd & mem_rdy);
    assign op          = cs ? alu_op : 5'd0;
    // decode straight to the first state after accept; FIN here means illegal
    always_comb begin
        dec_state = FIN;
        dec_op    = {2'b00, instr[5:3]};
        dec_sel   = instr[2:0];
        if (instr == APPROX_OPC) begin
            dec_state = LDREG;
            dec_op    = 5'b10010;
            dec_sel   = 3'b000;
        end else if (instr[7:6] == 2'b10)
            dec_state = instr[2:0] == 3'b110 ? FETCH : LDREG;
        else if (instr[7:6] == 2'b11 && instr[2:0] == 3'b110)
            dec_state = FETCH;
        else if (instr == 8'h3C || instr == 8'h3D) begin
            dec_state = EXEC;
            dec_op    = {4'b1000, instr[0]};
        end else if (instr[7:6] == 2'b00 && instr[2:0] == 3'b111 && instr[5:3] != 3'b100) begin
            dec_state = EXEC;
            dec_op    = {2'b01, instr[5:3]};
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            alu_op   <= '0;
            tmp_q    <= 1'b0;
            reg_oe   <= 1'b0;
            reg_sel  <= '0;
            mem_rd   <= 1'b0;
            mem_imm  <= 1'b0;
            cs       <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            accuracy <= ACC_RESET;
        end else begin
            tmp_q  <= 1'b0;
            reg_oe <= 1'b0;
            cs     <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            if (cfg_we && state == IDLE) accuracy <= cfg_data;
            case (state)
                IDLE: if (instr_valid) begin
                    state   <= dec_state;
                    alu_op  <= dec_op;
                    reg_sel <= dec_sel;
                    mem_imm <= instr[6];
                    cnt     <= '0;
                    reg_oe  <= dec_state == LDREG;
                    tmp_q   <= dec_state == LDREG;
                    mem_rd  <= dec_state == FETCH;
                    cs      <= dec_state == EXEC;
                    done    <= dec_state == FIN;
                    err     <= dec_state == FIN;
                end
                LDREG: begin
                    state <= EXEC;
                    cs    <= 1'b1;
                end
                FETCH: if (mem_rdy) begin
                    state  <= EXEC;
                    mem_rd <= 1'b0;
                    cs     <= 1'b1;
                end else if (cnt == CW'(MEM_TIMEOUT - 1)) begin
                    state  <= FIN;
                    mem_rd <= 1'b0;
                    done   <= 1'b1;
                    err    <= 1'b1;
                end else
                    cnt <= cnt + 1'b1;
                EXEC: begin
                    state <= FIN;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
